// File: rtl/key_event.sv
// key_event: turns the debounced active-low key level into press/release/click/long/repeat strobes
module key_event #(
   parameter logic [31:0] LONG_CYCLES   = 32'd25_000_000,
   parameter logic [31:0] REPEAT_CYCLES = 32'd5_000_000,
   parameter bit          REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);
   typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
   state_t      state;
   logic [31:0] cnt;
   logic        prev;
   logic        fall, rise;
   assign fall = prev & ~key_level;
   assign rise = ~prev & key_level;
   // Edge tracking, hold-time state machine and registered one-cycle strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         prev          <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         click_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
      end else begin
         prev          <= key_level;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         click_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         case (state)
            IDLE: begin
               if (fall) begin
                  state       <= PRESSED;
                  cnt         <= '0;
                  press_pulse <= 1'b1;
                  held        <= 1'b1;
               end
            end
            PRESSED: begin
               if (rise) begin
                  state         <= IDLE;
                  release_pulse <= 1'b1;
                  click_pulse   <= 1'b1;
                  held          <= 1'b0;
               end else if (cnt == LONG_CYCLES - 32'd1) begin
                  state      <= LONG;
                  cnt        <= '0;
                  long_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            LONG: begin
               if (rise) begin
                  state         <= IDLE;
                  release_pulse <= 1'b1;
                  held          <= 1'b0;
               end else if (REPEAT_EN && cnt == REPEAT_CYCLES - 32'd1) begin
                  cnt          <= '0;
                  repeat_pulse <= 1'b1;
               end else if (cnt != '1) begin
                  cnt <= cnt + 32'd1;
               end
            end
            default: begin
               state <= IDLE;
               held  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: table, directed and random checks of key_event against a hold-time reference model
module tb_key_event;
   localparam int L = 10;
   localparam int R = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_level = 1'b1;
   logic press_p[2], rel_p[2], click_p[2], long_p[2], rep_p[2], held_p[2];
   int   pass_cnt = 0;
   int   total = 0;
   bit   m_pressed[2];
   int   m_hold[2];
   bit   m_prev = 1'b0;
   logic [5:0] exp_o[2];

   typedef struct {
      bit         r;
      bit         k;
      logic [5:0] e;
   } vec_t;
   vec_t tbl[13];

   key_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) dut_rep (
      .clk(clk), .rst(rst), .key_level(key_level),
      .press_pulse(press_p[0]), .release_pulse(rel_p[0]), .click_pulse(click_p[0]),
      .long_pulse(long_p[0]), .repeat_pulse(rep_p[0]), .held(held_p[0]));

   key_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) dut_norep (
      .clk(clk), .rst(rst), .key_level(key_level),
      .press_pulse(press_p[1]), .release_pulse(rel_p[1]), .click_pulse(click_p[1]),
      .long_pulse(long_p[1]), .repeat_pulse(rep_p[1]), .held(held_p[1]));

   always #5 clk = ~clk;

   function automatic logic [5:0] got(int i);
      return {press_p[i], rel_p[i], click_p[i], long_p[i], rep_p[i], held_p[i]};
   endfunction

   task automatic check(string name, logic [5:0] g, logic [5:0] w);
      total++;
      if (g === w) pass_cnt++;
      else $display("FAIL %s got=%b want=%b (press,rel,click,long,rep,held)", name, g, w);
   endtask

   // Reference: count cycles since press; long at L, repeats at L+n*R, click only if released by L
   task automatic model(bit r, bit k);
      for (int i = 0; i < 2; i++) begin
         exp_o[i] = '0;
         if (r) begin
            m_pressed[i] = 1'b0;
            m_hold[i] = 0;
         end else if (!m_pressed[i]) begin
            if (m_prev && !k) begin
               m_pressed[i] = 1'b1;
               m_hold[i] = 0;
               exp_o[i][5] = 1'b1;
            end
         end else begin
            m_hold[i]++;
            if (!m_prev && k) begin
               exp_o[i][4] = 1'b1;
               exp_o[i][3] = (m_hold[i] <= L);
               m_pressed[i] = 1'b0;
            end else begin
               exp_o[i][2] = (m_hold[i] == L);
               exp_o[i][1] = (i == 0) && m_hold[i] > L && (m_hold[i] - L) % R == 0;
            end
         end
         exp_o[i][0] = m_pressed[i];
      end
      m_prev = r ? 1'b0 : k;
   endtask

   task automatic step(bit r, bit k);
      rst = r;
      key_level = k;
      @(posedge clk);
      model(r, k);
      #1;
      check("model_rep", got(0), exp_o[0]);
      check("model_norep", got(1), exp_o[1]);
   endtask

   task automatic expect2(string name, logic [5:0] e0, logic [5:0] e1);
      check({name, "_rep"}, got(0), e0);
      check({name, "_norep"}, got(1), e1);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 6'b000000};
      tbl[1]  = '{1'b0, 1'b1, 6'b000000};
      tbl[2]  = '{1'b0, 1'b1, 6'b000000};
      tbl[3]  = '{1'b0, 1'b0, 6'b100001};
      tbl[4]  = '{1'b0, 1'b0, 6'b000001};
      tbl[5]  = '{1'b0, 1'b0, 6'b000001};
      tbl[6]  = '{1'b0, 1'b0, 6'b000001};
      tbl[7]  = '{1'b0, 1'b0, 6'b000001};
      tbl[8]  = '{1'b0, 1'b1, 6'b011000};
      tbl[9]  = '{1'b0, 1'b1, 6'b000000};
      tbl[10] = '{1'b0, 1'b0, 6'b100001};
      tbl[11] = '{1'b0, 1'b1, 6'b011000};
      tbl[12] = '{1'b0, 1'b1, 6'b000000};
      #1;
      for (int v = 0; v < 13; v++) begin
         step(tbl[v].r, tbl[v].k);
         expect2($sformatf("tbl%0d", v), tbl[v].e, tbl[v].e);
      end
      step(1'b0, 1'b0);
      expect2("hold_press", 6'b100001, 6'b100001);
      for (int i = 1; i <= 40; i++) begin
         step(1'b0, 1'b0);
         expect2($sformatf("hold%0d", i),
                 {3'b000, i == L, i > L && (i - L) % R == 0, 1'b1},
                 {3'b000, i == L, 1'b0, 1'b1});
      end
      step(1'b0, 1'b1);
      expect2("long_release", 6'b010000, 6'b010000);
      step(1'b0, 1'b0);
      for (int i = 1; i < L; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      expect2("race_release", 6'b011000, 6'b011000);
      step(1'b0, 1'b1);
      expect2("race_after", 6'b000000, 6'b000000);
      step(1'b0, 1'b0);
      for (int i = 1; i <= 12; i++) step(1'b0, 1'b0);
      expect2("in_long", 6'b000001, 6'b000001);
      step(1'b1, 1'b0);
      expect2("rst_mid_long", 6'b000000, 6'b000000);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      expect2("low_after_rst", 6'b000000, 6'b000000);
      step(1'b0, 1'b1);
      expect2("rise_after_rst", 6'b000000, 6'b000000);
      step(1'b0, 1'b0);
      expect2("repress_after_rst", 6'b100001, 6'b100001);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      expect2("held_thru_rst", 6'b000000, 6'b000000);
      step(1'b0, 1'b1);
      expect2("no_release", 6'b000000, 6'b000000);
      step(1'b0, 1'b0);
      expect2("next_press", 6'b100001, 6'b100001);
      step(1'b0, 1'b1);
      expect2("next_click", 6'b011000, 6'b011000);
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            step(1'b1, 1'($urandom_range(0, 1)));
         end else begin
            bit lvl = 1'($urandom_range(0, 1));
            int len = $urandom_range(1, 25);
            for (int c = 0; c < len; c++) step(1'b0, lvl);
         end
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
